ycr_arb_router: RTL and testbench

Request router and response steerer for the shared side of the two-initiator round-robin arbiter. It takes the arbiter's registered grant and forwards the granted initiator's core-interface request (cmd/width/addr/wdata) to the single target port. On each accepted request it returns the `ack` pulse the arbiter waits on. It records the owner of every accepted request in an in-order tag FIFO, so that pipelined target responses (rdata/resp) are steered back to the initiator that issued them.

---
 rtl/ycr_arb_router.sv | 162 ++++++++++++++++
 tb/tb_ycr_arb_router.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycr_arb_router.sv
`default_nettype none
// ============================================================================
// Module   : ycr_arb_router
// Purpose  : Shared-side request router / response steerer for a two-initiator
//            round-robin arbiter. Forwards the granted initiator's request to
//            the single target port, returns the accept pulse to the arbiter,
//            and keeps an in-order owner-tag FIFO so pipelined target
//            responses are steered back to the initiator that issued them.
// Ports    : clk, rstn             - clock, async active-low reset
//            gnt                   - arbiter grant (00=p0, 01=p1, 11/10=none)
//            arb_ack               - request-accepted pulse to the arbiter
//            pN_req/req_ack/cmd/width/addr/wdata - initiator request side
//            pN_rdata/resp         - initiator response side
//            tgt_*                 - target request / response port
//            err_unexp             - sticky: response with no outstanding tag
// Revision : 1.0 - initial release
// ============================================================================
module ycr_arb_router #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    gnt,
    output logic          arb_ack,
    input  logic          p0_req,
    input  logic          p1_req,
    output logic          p0_req_ack,
    output logic          p1_req_ack,
    input  logic          p0_cmd,
    input  logic          p1_cmd,
    input  logic [1:0]    p0_width,
    input  logic [1:0]    p1_width,
    input  logic [AW-1:0] p0_addr,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic [DW-1:0] p1_wdata,
    output logic [DW-1:0] p0_rdata,
    output logic [DW-1:0] p1_rdata,
    output logic [1:0]    p0_resp,
    output logic [1:0]    p1_resp,
    output logic          tgt_req,
    input  logic          tgt_req_ack,
    output logic          tgt_cmd,
    output logic [1:0]    tgt_width,
    output logic [AW-1:0] tgt_addr,
    output logic [DW-1:0] tgt_wdata,
    input  logic [DW-1:0] tgt_rdata,
    input  logic [1:0]    tgt_resp,
    output logic          err_unexp
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Tag FIFO state
    logic [DEPTH-1:0] tags_q;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             err_q,    err_d;

    logic sel0, sel1, sel_req, full, empty, acc, push_tag, resp_vld, pop, head_tag;

    assign sel0    = (gnt == 2'b00);
    assign sel1    = (gnt == 2'b01);
    assign sel_req = (sel0 & p0_req) | (sel1 & p1_req);
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);

    // A full FIFO masks the request, so push and pop never collide when full.
    assign tgt_req  = sel_req & ~full;
    assign acc      = tgt_req & tgt_req_ack;
    assign push_tag = sel1;
    assign arb_ack  = acc;
    assign p0_req_ack = acc & sel0;
    assign p1_req_ack = acc & sel1;

    always_comb begin
        tgt_cmd   = 1'b0;
        tgt_width = '0;
        tgt_addr  = '0;
        tgt_wdata = '0;
        if (sel0) begin
            tgt_cmd   = p0_cmd;
            tgt_width = p0_width;
            tgt_addr  = p0_addr;
            tgt_wdata = p0_wdata;
        end else if (sel1) begin
            tgt_cmd   = p1_cmd;
            tgt_width = p1_width;
            tgt_addr  = p1_addr;
            tgt_wdata = p1_wdata;
        end
    end

    // Response steering uses the head tag as it stood before any same-cycle push.
    assign resp_vld = (tgt_resp != 2'b00);
    assign pop      = resp_vld & ~empty;
    assign head_tag = tags_q[rd_ptr_q];

    always_comb begin
        p0_resp  = 2'b00;
        p1_resp  = 2'b00;
        p0_rdata = '0;
        p1_rdata = '0;
        if (pop) begin
            if (head_tag) begin
                p1_resp  = tgt_resp;
                p1_rdata = tgt_rdata;
            end else begin
                p0_resp  = tgt_resp;
                p0_rdata = tgt_rdata;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (resp_vld & empty);
        if (acc) begin
            wr_ptr_d = (DEPTH > 1) ? wr_ptr_q + 1'b1 : '0;
        end
        if (pop) begin
            rd_ptr_d = (DEPTH > 1) ? rd_ptr_q + 1'b1 : '0;
        end
        case ({acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Tag storage carries no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (acc) begin
            tags_q[wr_ptr_q] <= push_tag;
        end
    end

    assign err_unexp = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ycr_arb_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_ycr_arb_router
// Purpose  : Directed self-checking bench for ycr_arb_router (DEPTH = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ycr_arb_router;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [1:0]    gnt;
    logic          arb_ack;
    logic          p0_req, p1_req, p0_req_ack, p1_req_ack;
    logic          p0_cmd, p1_cmd;
    logic [1:0]    p0_width, p1_width;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    logic [1:0]    p0_resp, p1_resp;
    logic          tgt_req, tgt_req_ack, tgt_cmd;
    logic [1:0]    tgt_width;
    logic [AW-1:0] tgt_addr;
    logic [DW-1:0] tgt_wdata, tgt_rdata;
    logic [1:0]    tgt_resp;
    logic          err_unexp;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ycr_arb_router #(.AW(AW), .DW(DW), .DEPTH(2)) dut (
        .clk(clk), .rstn(rstn), .gnt(gnt), .arb_ack(arb_ack),
        .p0_req(p0_req), .p1_req(p1_req),
        .p0_req_ack(p0_req_ack), .p1_req_ack(p1_req_ack),
        .p0_cmd(p0_cmd), .p1_cmd(p1_cmd),
        .p0_width(p0_width), .p1_width(p1_width),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_resp(p0_resp), .p1_resp(p1_resp),
        .tgt_req(tgt_req), .tgt_req_ack(tgt_req_ack),
        .tgt_cmd(tgt_cmd), .tgt_width(tgt_width),
        .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
        .tgt_rdata(tgt_rdata), .tgt_resp(tgt_resp),
        .err_unexp(err_unexp)
    );

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        gnt         = 2'b11;
        p0_req      = 1'b0;
        p1_req      = 1'b0;
        tgt_req_ack = 1'b0;
        tgt_resp    = 2'b00;
        tgt_rdata   = '0;
    endtask

    task automatic test_reset();
        idle();
        p0_cmd = 1'b0; p0_width = 2'b10; p0_addr = 32'h100; p0_wdata = 32'h1111_0000;
        p1_cmd = 1'b1; p1_width = 2'b01; p1_addr = 32'h200; p1_wdata = 32'h0000_CAFE;
        rstn = 1'b0;
        #2;
        n_checks++;
        if ({arb_ack, p0_req_ack, p1_req_ack, tgt_req, p0_resp, p1_resp, err_unexp} !== 9'd0)
            $display("FAIL reset_ctrl: got %b required 0", {arb_ack, p0_req_ack, p1_req_ack, tgt_req, p0_resp, p1_resp, err_unexp});
        else n_pass++;
        n_checks++;
        if ({tgt_cmd, tgt_width, tgt_addr, tgt_wdata, p0_rdata, p1_rdata} !== '0)
            $display("FAIL reset_data: got %h %h %h %h required 0", tgt_addr, tgt_wdata, p0_rdata, p1_rdata);
        else n_pass++;
        cyc();
        cyc();
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_single_read();
        gnt = 2'b00; p0_req = 1'b1; tgt_req_ack = 1'b1;
        #1;
        n_checks++;
        if ({tgt_req, p0_req_ack, arb_ack, p1_req_ack} !== 4'b1110)
            $display("FAIL rd_accept: got %b required 1110", {tgt_req, p0_req_ack, arb_ack, p1_req_ack});
        else n_pass++;
        n_checks++;
        if ({tgt_cmd, tgt_width, tgt_addr} !== {1'b0, 2'b10, 32'h100})
            $display("FAIL rd_fields: got %b %b %h required 0 10 00000100", tgt_cmd, tgt_width, tgt_addr);
        else n_pass++;
        cyc();
        idle();
        #1;
        n_checks++;
        if ({arb_ack, p0_req_ack} !== 2'b00)
            $display("FAIL rd_ack_pulse: got %b required 00", {arb_ack, p0_req_ack});
        else n_pass++;
        cyc();
        tgt_resp = 2'b01; tgt_rdata = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({p0_resp, p0_rdata, p1_resp} !== {2'b01, 32'hDEADBEEF, 2'b00})
            $display("FAIL rd_resp: got %b %h %b required 01 deadbeef 00", p0_resp, p0_rdata, p1_resp);
        else n_pass++;
        cyc();
        idle();
        #1;
        n_checks++;
        if ({p0_resp, p1_resp} !== 4'b0000)
            $display("FAIL rd_resp_end: got %b required 0000", {p0_resp, p1_resp});
        else n_pass++;
    endtask

    // p0, p1 accepted (FIFO full), p1 blocked, then responses 1,2,3 with a
    // further p0 accept slipped in once an entry frees up.
    task automatic test_interleave_full();
        cyc();
        gnt = 2'b00; p0_req = 1'b1; tgt_req_ack = 1'b1;
        cyc();
        gnt = 2'b01; p0_req = 1'b0; p1_req = 1'b1;
        #1;
        n_checks++;
        if ({tgt_req, p1_req_ack, tgt_cmd, tgt_width, tgt_addr, tgt_wdata} !== {1'b1, 1'b1, 1'b1, 2'b01, 32'h200, 32'h0000_CAFE})
            $display("FAIL il_p1_accept: got %b %b %h %h required 1 1 00000200 0000cafe", tgt_req, p1_req_ack, tgt_addr, tgt_wdata);
        else n_pass++;
        cyc();
        #1;
        n_checks++;
        if ({tgt_req, p1_req_ack, arb_ack} !== 3'b000)
            $display("FAIL full_block: got %b required 000", {tgt_req, p1_req_ack, arb_ack});
        else n_pass++;
        cyc();
        tgt_resp = 2'b01; tgt_rdata = 32'd1;
        #1;
        n_checks++;
        if ({p0_resp, p0_rdata, p1_resp, tgt_req} !== {2'b01, 32'd1, 2'b00, 1'b0})
            $display("FAIL il_resp1: got %b %h %b req %b required 01 00000001 00 req 0", p0_resp, p0_rdata, p1_resp, tgt_req);
        else n_pass++;
        cyc();
        gnt = 2'b00; p1_req = 1'b0; p0_req = 1'b1;
        tgt_resp = 2'b01; tgt_rdata = 32'd2;
        #1;
        n_checks++;
        if ({tgt_req, p0_req_ack, p1_resp, p1_rdata, p0_resp} !== {1'b1, 1'b1, 2'b01, 32'd2, 2'b00})
            $display("FAIL il_resp2: got req %b ack %b %b %h p0 %b required 1 1 01 00000002 00", tgt_req, p0_req_ack, p1_resp, p1_rdata, p0_resp);
        else n_pass++;
        cyc();
        idle();
        tgt_resp = 2'b01; tgt_rdata = 32'd3;
        #1;
        n_checks++;
        if ({p0_resp, p0_rdata, p1_resp} !== {2'b01, 32'd3, 2'b00})
            $display("FAIL il_resp3: got %b %h %b required 01 00000003 00", p0_resp, p0_rdata, p1_resp);
        else n_pass++;
        cyc();
        idle();
    endtask

    task automatic test_push_pop();
        cyc();
        gnt = 2'b00; p0_req = 1'b1; tgt_req_ack = 1'b1;
        cyc();
        gnt = 2'b01; p0_req = 1'b0; p1_req = 1'b1;
        tgt_resp = 2'b01; tgt_rdata = 32'h55;
        #1;
        n_checks++;
        if ({p1_req_ack, p0_resp, p0_rdata, p1_resp} !== {1'b1, 2'b01, 32'h55, 2'b00})
            $display("FAIL pp_same_cycle: got ack %b %b %h p1 %b required 1 01 00000055 00", p1_req_ack, p0_resp, p0_rdata, p1_resp);
        else n_pass++;
        cyc();
        idle();
        tgt_resp = 2'b10; tgt_rdata = 32'h66;
        #1;
        n_checks++;
        if ({p1_resp, p1_rdata, p0_resp} !== {2'b10, 32'h66, 2'b00})
            $display("FAIL pp_head_tag1: got %b %h p0 %b required 10 00000066 00", p1_resp, p1_rdata, p0_resp);
        else n_pass++;
        cyc();
        idle();
        #1;
        n_checks++;
        if (err_unexp !== 1'b0)
            $display("FAIL pp_no_err: got %b required 0", err_unexp);
        else n_pass++;
    endtask

    task automatic test_unexpected();
        cyc();
        tgt_resp = 2'b10; tgt_rdata = 32'h77;
        #1;
        n_checks++;
        if ({p0_resp, p1_resp, err_unexp} !== 5'b00000)
            $display("FAIL unexp_drop: got %b required 00000", {p0_resp, p1_resp, err_unexp});
        else n_pass++;
        cyc();
        idle();
        #1;
        n_checks++;
        if (err_unexp !== 1'b1)
            $display("FAIL unexp_set: got %b required 1", err_unexp);
        else n_pass++;
        cyc();
        cyc();
        n_checks++;
        if (err_unexp !== 1'b1)
            $display("FAIL unexp_sticky: got %b required 1", err_unexp);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        cyc();
        gnt = 2'b00; p0_req = 1'b1; tgt_req_ack = 1'b1;
        cyc();
        gnt = 2'b01; p0_req = 1'b0; p1_req = 1'b1;
        cyc();
        gnt = 2'b00; p1_req = 1'b0; p0_req = 1'b1; tgt_req_ack = 1'b0;
        #1;
        n_checks++;
        if (tgt_req !== 1'b0)
            $display("FAIL rm_full: got %b required 0", tgt_req);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({tgt_req, err_unexp} !== 2'b10)
            $display("FAIL rm_cleared: got %b required 10", {tgt_req, err_unexp});
        else n_pass++;
        cyc();
        rstn = 1'b1;
        idle();
        cyc();
        tgt_resp = 2'b01; tgt_rdata = 32'h99;
        #1;
        n_checks++;
        if ({p0_resp, p1_resp} !== 4'b0000)
            $display("FAIL rm_drop: got %b required 0000", {p0_resp, p1_resp});
        else n_pass++;
        cyc();
        idle();
        #1;
        n_checks++;
        if (err_unexp !== 1'b1)
            $display("FAIL rm_err: got %b required 1", err_unexp);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_interleave_full();
        test_push_pop();
        test_unexpected();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
